// File: rtl/sdam_master.sv
// sdam_master: transmit-side controller for the SDAM serial link.
// Arbitrates N_REQ requesters. It serializes the winning 8-bit address and
// 16-bit data word onto sda as one 27-cycle frame:
//   start(0), pad(1), addr[0..7], data[0..15], tail(1)
// After each frame it drives GAP optional idle cycles, then returns to IDLE.
//
// Ports:
//   scl      clock, all logic on posedge
//   reset    synchronous active-high reset
//   req      per-requester request, held until gnt
//   addr_in  requester i address in [8i+7:8i]
//   data_in  requester i data in [16i+15:16i]
//   gnt      one-hot pulse in the start-bit cycle (request latched)
//   done     one-hot pulse in the tail cycle (frame fully sent)
//   busy     high whenever the FSM is not IDLE
//   sda      registered serial line, idles high
//
// Build option: define SDAM_MASTER_FIXED_PRIO_EN for fixed priority, where the
// lowest index wins. The default build uses round-robin arbitration.
module sdam_master #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned GAP   = 0
) (
   input  logic                  scl,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ*8-1:0]    addr_in,
   input  logic [N_REQ*16-1:0]   data_in,
   output logic [N_REQ-1:0]      gnt,
   output logic [N_REQ-1:0]      done,
   output logic                  busy,
   output logic                  sda
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned SH_W  = 24;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_PAD,
      S_ADDR,
      S_DATA,
      S_TAIL,
      S_GAP
   } state_e;

   state_e              state_q;
   logic [SH_W-1:0]     shift_q;
   logic [3:0]          bit_cnt_q;
   logic [3:0]          gap_cnt_q;
   logic [IDX_W-1:0]    win_q;
   logic [N_REQ-1:0]    gnt_q;
   logic [N_REQ-1:0]    done_q;
   logic                busy_q;
   logic                sda_q;

   logic                win_vld_c;
   logic [IDX_W-1:0]    win_idx_c;
   logic [7:0]          win_addr_c;
   logic [15:0]         win_data_c;

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] oh;
      oh = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         oh[i] = (idx == IDX_W'(i));
      end
      return oh;
   endfunction

`ifdef SDAM_MASTER_FIXED_PRIO_EN
   // Fixed priority: scan from the top so the lowest requesting index wins.
   always_comb begin
      win_vld_c = 1'b0;
      win_idx_c = '0;
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_vld_c = 1'b1;
            win_idx_c = IDX_W'(i);
         end
      end
   end
`else
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] cand_c;

   // Round-robin: search starts one past the last winner and wraps.
   always_comb begin
      win_vld_c = 1'b0;
      win_idx_c = '0;
      cand_c    = '0;
      for (int k = 1; k <= int'(N_REQ); k++) begin
         cand_c = IDX_W'((int'(ptr_q) + k) % int'(N_REQ));
         if (!win_vld_c && req[cand_c]) begin
            win_vld_c = 1'b1;
            win_idx_c = cand_c;
         end
      end
   end
`endif

   // Winner payload mux.
   always_comb begin
      win_addr_c = '0;
      win_data_c = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (win_idx_c == IDX_W'(i)) begin
            win_addr_c = addr_in[i*8 +: 8];
            win_data_c = data_in[i*16 +: 16];
         end
      end
   end

   // Frame FSM; every output is registered alongside the state.
   always_ff @(posedge scl) begin
      if (reset) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         win_q     <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         busy_q    <= 1'b0;
         sda_q     <= 1'b1;
`ifndef SDAM_MASTER_FIXED_PRIO_EN
         ptr_q     <= IDX_W'(N_REQ - 1);
`endif
      end else begin
         gnt_q  <= '0;
         done_q <= '0;
         case (state_q)
            S_IDLE: begin
               sda_q  <= 1'b1;
               busy_q <= 1'b0;
               if (win_vld_c) begin
                  shift_q <= {win_data_c, win_addr_c};
                  win_q   <= win_idx_c;
                  gnt_q   <= onehot(win_idx_c);
                  sda_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_START;
`ifndef SDAM_MASTER_FIXED_PRIO_EN
                  ptr_q   <= win_idx_c;
`endif
               end
            end
            S_START: begin
               sda_q   <= 1'b1;
               state_q <= S_PAD;
            end
            S_PAD: begin
               // Launch addr[0]; the shifter then feeds one bit per edge.
               sda_q     <= shift_q[0];
               shift_q   <= {1'b1, shift_q[SH_W-1:1]};
               bit_cnt_q <= '0;
               state_q   <= S_ADDR;
            end
            S_ADDR: begin
               sda_q   <= shift_q[0];
               shift_q <= {1'b1, shift_q[SH_W-1:1]};
               if (bit_cnt_q == 4'd7) begin
                  bit_cnt_q <= '0;
                  state_q   <= S_DATA;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 4'd1;
               end
            end
            S_DATA: begin
               if (bit_cnt_q == 4'd15) begin
                  sda_q   <= 1'b1;
                  done_q  <= onehot(win_q);
                  state_q <= S_TAIL;
               end else begin
                  sda_q     <= shift_q[0];
                  shift_q   <= {1'b1, shift_q[SH_W-1:1]};
                  bit_cnt_q <= bit_cnt_q + 4'd1;
               end
            end
            S_TAIL: begin
               sda_q <= 1'b1;
               if (GAP > 0) begin
                  gap_cnt_q <= '0;
                  state_q   <= S_GAP;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_GAP: begin
               sda_q <= 1'b1;
               if (gap_cnt_q == 4'(GAP - 1)) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 4'd1;
               end
            end
            default: begin
               sda_q   <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt  = gnt_q;
   assign done = done_q;
   assign busy = busy_q;
   assign sda  = sda_q;

endmodule
